// File: rtl/tohost_signature_dumper.sv
// tohost_signature_dumper
// Watches core writes to the tohost word. The first nonzero write halts the
// core and streams the signature region [begin_sig, end_sig) out one 32-bit
// word at a time over a valid/ready port. The dump ends in a sticky DONE
// state that only reset leaves.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | core running; tohost writes accepted
// READ   | mem_rd_en high for one cycle at ptr
// WAIT   | read data arrives; captured into sig_data
// SEND   | sig_valid high until the consumer takes the word
// DONE   | dump finished; halt and done held until reset

module tohost_signature_dumper #(
    parameter int unsigned           ADDR_W      = 32,
    parameter logic [ADDR_W-1:0]     TOHOST_ADDR = ADDR_W'(32'h0000_1000)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_we,
    input  logic [31:0]       bus_wdata,
    output logic [31:0]       bus_rdata,
    input  logic [ADDR_W-1:0] begin_sig,
    input  logic [ADDR_W-1:0] end_sig,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [31:0]       mem_rd_data,
    output logic              sig_valid,
    input  logic              sig_ready,
    output logic [31:0]       sig_data,
    output logic              sig_last,
    output logic              halt,
    output logic              done,
    output logic [31:0]       exit_code
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_WAIT = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state_q;
    logic [31:0]       tohost_q;
    logic [31:0]       exit_code_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] mem_rd_addr_q;
    logic              mem_rd_en_q;
    logic [31:0]       sig_data_q;
    logic              sig_valid_q;
    logic              sig_last_q;
    logic              halt_q;
    logic              done_q;

    logic              tohost_wr_d;
    logic [ADDR_W-1:0] ptr_inc_d;
    logic              ptr_is_last_d;

    // Decode of the tohost write strobe and the next-word pointer.
    always_comb begin
        tohost_wr_d   = bus_we && (bus_addr == TOHOST_ADDR);
        ptr_inc_d     = ptr_q + ADDR_W'(4);
        ptr_is_last_d = (ptr_inc_d == end_sig);
    end

    // Read-back of the tohost register; zero for any other address.
    always_comb begin
        bus_rdata = (bus_addr == TOHOST_ADDR) ? tohost_q : 32'd0;
    end

    // Dump sequencer; every output is registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            tohost_q      <= 32'd0;
            exit_code_q   <= 32'd0;
            ptr_q         <= '0;
            mem_rd_addr_q <= '0;
            mem_rd_en_q   <= 1'b0;
            sig_data_q    <= 32'd0;
            sig_valid_q   <= 1'b0;
            sig_last_q    <= 1'b0;
            halt_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (tohost_wr_d) begin
                        tohost_q <= bus_wdata;
                        if (bus_wdata != 32'd0) begin
                            exit_code_q <= bus_wdata;
                            halt_q      <= 1'b1;
                            ptr_q       <= begin_sig;
                            if (begin_sig != end_sig) begin
                                state_q       <= S_READ;
                                mem_rd_en_q   <= 1'b1;
                                mem_rd_addr_q <= begin_sig;
                            end else begin
                                // Empty region: done follows one cycle later from DONE.
                                state_q <= S_DONE;
                            end
                        end
                    end
                end
                S_READ: begin
                    mem_rd_en_q <= 1'b0;
                    state_q     <= S_WAIT;
                end
                S_WAIT: begin
                    sig_data_q  <= mem_rd_data;
                    sig_valid_q <= 1'b1;
                    sig_last_q  <= ptr_is_last_d;
                    state_q     <= S_SEND;
                end
                S_SEND: begin
                    if (sig_ready) begin
                        sig_valid_q <= 1'b0;
                        ptr_q       <= ptr_inc_d;
                        if (sig_last_q) begin
                            sig_last_q <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= S_DONE;
                        end else begin
                            mem_rd_en_q   <= 1'b1;
                            mem_rd_addr_q <= ptr_inc_d;
                            state_q       <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    done_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_rd_en   = mem_rd_en_q;
    assign mem_rd_addr = mem_rd_addr_q;
    assign sig_valid   = sig_valid_q;
    assign sig_data    = sig_data_q;
    assign sig_last    = sig_last_q;
    assign halt        = halt_q;
    assign done        = done_q;
    assign exit_code   = exit_code_q;

endmodule

// File: tb/tb_tohost_signature_dumper.sv
// Bench for tohost_signature_dumper: directed scenarios plus randomized dumps,
// checked against an address-range model of the expected signature stream.

module tb_tohost_signature_dumper;

    localparam logic [31:0] TOHOST = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic [31:0] begin_sig;
    logic [31:0] end_sig;
    logic        mem_rd_en;
    logic [31:0] mem_rd_addr;
    logic [31:0] mem_rd_data;
    logic        sig_valid;
    logic        sig_ready;
    logic [31:0] sig_data;
    logic        sig_last;
    logic        halt;
    logic        done;
    logic [31:0] exit_code;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mem [logic [31:0]];

    tohost_signature_dumper #(.ADDR_W(32), .TOHOST_ADDR(TOHOST)) dut (
        .clk(clk), .reset(reset),
        .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .begin_sig(begin_sig), .end_sig(end_sig),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .sig_valid(sig_valid), .sig_ready(sig_ready), .sig_data(sig_data), .sig_last(sig_last),
        .halt(halt), .done(done), .exit_code(exit_code)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'hBAD0_0000 ^ a;
    endfunction

    // Memory: data one cycle after the request, garbage otherwise.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem_read(mem_rd_addr);
        else           mem_rd_data <= $urandom();
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        bus_addr = TOHOST;
        #0;
        check({tag, "_rdata"},    bus_rdata,         32'd0);
        check({tag, "_exit"},     exit_code,         32'd0);
        check({tag, "_halt"},     {31'd0, halt},     32'd0);
        check({tag, "_done"},     {31'd0, done},     32'd0);
        check({tag, "_valid"},    {31'd0, sig_valid},32'd0);
        check({tag, "_last"},     {31'd0, sig_last}, 32'd0);
        check({tag, "_data"},     sig_data,          32'd0);
        check({tag, "_rd_en"},    {31'd0, mem_rd_en},32'd0);
        check({tag, "_rd_addr"},  mem_rd_addr,       32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus_we = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // mode 0: ready always high; 1: random ready; 2: ready low 5 cycles on beat 2.
    task automatic run_dump(input string tag, input logic [31:0] b, input logic [31:0] e,
                            input logic [31:0] code, input int mode, input bit poke);
        logic [31:0] exp_q[$];
        logic [31:0] got_data[$];
        bit          got_last[$];
        int          got_k[$];
        int          rd_cnt = 0, done_k = -1, first_valid_k = -1, stall = 0, n;
        bit          prev_valid = 0, prev_ready = 0, prev_last = 0, poked = 0;
        logic [31:0] prev_data = 0;

        for (logic [31:0] a = b; a < e; a += 4) exp_q.push_back(mem_read(a));
        n = exp_q.size();

        begin_sig = b;
        end_sig   = e;
        bus_addr  = TOHOST;
        bus_we    = 1'b1;
        bus_wdata = code;
        sig_ready = (mode == 0);
        step();
        bus_we = 1'b0;
        check({tag, "_halt_T1"},  {31'd0, halt},      32'd1);
        check({tag, "_rden_T1"},  {31'd0, mem_rd_en}, (n != 0) ? 32'd1 : 32'd0);
        check({tag, "_exit_T1"},  exit_code,          code);

        for (int k = 1; k <= 400; k++) begin
            case (mode)
                0: sig_ready = 1'b1;
                1: sig_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (got_data.size() == 1 && sig_valid && stall < 5) begin
                        sig_ready = 1'b0;
                        stall++;
                    end else begin
                        sig_ready = 1'b1;
                    end
                end
            endcase
            if (poke && sig_valid && !poked) begin
                bus_we    = 1'b1;
                bus_wdata = 32'h0000_DEAD;
                poked     = 1;
            end else begin
                bus_we = 1'b0;
            end
            #0;
            if (mem_rd_en) begin
                check({tag, "_rd_addr"}, mem_rd_addr, b + 32'(rd_cnt) * 4);
                rd_cnt++;
            end
            if (sig_valid && first_valid_k < 0) first_valid_k = k;
            if (prev_valid && !prev_ready) begin
                check({tag, "_hold_valid"}, {31'd0, sig_valid}, 32'd1);
                check({tag, "_hold_data"},  sig_data,           prev_data);
                check({tag, "_hold_last"},  {31'd0, sig_last},  {31'd0, prev_last});
            end
            if (sig_valid && sig_ready) begin
                got_data.push_back(sig_data);
                got_last.push_back(sig_last);
                got_k.push_back(k);
            end
            if (done) begin
                done_k = k;
                break;
            end
            prev_valid = sig_valid;
            prev_ready = sig_ready;
            prev_data  = sig_data;
            prev_last  = sig_last;
            step();
        end
        bus_we = 1'b0;

        check({tag, "_done_seen"}, (done_k >= 0) ? 32'd1 : 32'd0, 32'd1);
        check({tag, "_beats"},     32'(got_data.size()), 32'(n));
        for (int i = 0; i < n && i < got_data.size(); i++) begin
            check($sformatf("%s_beat%0d_data", tag, i), got_data[i], exp_q[i]);
            check($sformatf("%s_beat%0d_last", tag, i), {31'd0, got_last[i]},
                  (i == n - 1) ? 32'd1 : 32'd0);
        end
        check({tag, "_rd_count"}, 32'(rd_cnt), 32'(n));
        if (n == 0) begin
            check({tag, "_done_k_empty"}, 32'(done_k), 32'd2);
        end else if (got_k.size() == n) begin
            check({tag, "_done_after_last"}, 32'(done_k), 32'(got_k[n-1] + 1));
            if (mode == 0) begin
                check({tag, "_first_valid_T3"}, 32'(first_valid_k), 32'd3);
                for (int i = 1; i < n; i++)
                    check($sformatf("%s_spacing%0d", tag, i), 32'(got_k[i] - got_k[i-1]), 32'd3);
            end
        end
        bus_addr = TOHOST;
        #0;
        check({tag, "_exit_end"},  exit_code, code);
        check({tag, "_rdata_end"}, bus_rdata, code);
        check({tag, "_halt_end"},  {31'd0, halt}, 32'd1);

        // DONE is sticky, ignores tohost writes, and issues no reads.
        bus_we    = 1'b1;
        bus_wdata = 32'hFFFF_0001;
        step();
        bus_we = 1'b0;
        rd_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (mem_rd_en || sig_valid || !done) rd_cnt++;
            step();
        end
        check({tag, "_done_quiet"}, 32'(rd_cnt), 32'd0);
        check({tag, "_rdata_done"}, bus_rdata, code);
    endtask

    initial begin
        reset     = 1'b1;
        bus_addr  = 32'd0;
        bus_we    = 1'b0;
        bus_wdata = 32'd0;
        begin_sig = 32'h2000;
        end_sig   = 32'h2010;
        sig_ready = 1'b0;

        for (int i = 0; i < 4; i++) mem[32'h2000 + 32'(i) * 4] = 32'h11 * 32'(i + 1);

        do_reset();
        check_reset_outputs("reset");

        // Zero write: register stays zero, no dump.
        bus_addr  = TOHOST;
        bus_we    = 1'b1;
        bus_wdata = 32'd0;
        step();
        bus_we = 1'b0;
        begin
            int rd = 0;
            for (int i = 0; i < 4; i++) begin
                if (mem_rd_en || halt) rd++;
                step();
            end
            check("zero_write_quiet", 32'(rd), 32'd0);
        end
        check("zero_write_rdata", bus_rdata, 32'd0);
        bus_addr = 32'h0000_1004;
        #0;
        check("rdata_other_addr", bus_rdata, 32'd0);

        run_dump("basic", 32'h2000, 32'h2010, 32'd1, 0, 0);

        do_reset();
        run_dump("stall", 32'h2000, 32'h2010, 32'd1, 2, 0);

        do_reset();
        run_dump("empty", 32'h3000, 32'h3000, 32'd5, 0, 0);

        do_reset();
        run_dump("poke", 32'h2000, 32'h2010, 32'h0000_0042, 0, 1);

        // Reset during WAIT of word 2 (cycle T+5 with ready high).
        do_reset();
        bus_addr  = TOHOST;
        bus_we    = 1'b1;
        bus_wdata = 32'h9;
        sig_ready = 1'b1;
        step();
        bus_we = 1'b0;
        for (int i = 0; i < 4; i++) step();
        reset = 1'b1;
        step();
        check_reset_outputs("mid_reset");
        reset = 1'b0;
        step();
        check("mid_reset_idle_halt", {31'd0, halt}, 32'd0);
        run_dump("restart", 32'h2000, 32'h2010, 32'h9, 0, 0);

        // Reset and trigger in the same cycle: reset wins.
        reset     = 1'b1;
        bus_addr  = TOHOST;
        bus_we    = 1'b1;
        bus_wdata = 32'h7;
        step();
        bus_we = 1'b0;
        reset  = 1'b0;
        check_reset_outputs("reset_vs_trig");
        step();
        check("reset_vs_trig_halt", {31'd0, halt}, 32'd0);

        // Randomized regions, contents, exit codes and backpressure.
        for (int r = 0; r < 4; r++) begin
            logic [31:0] b, e, code;
            b    = 32'h4000 + 32'($urandom_range(0, 255)) * 4;
            e    = b + 32'($urandom_range(0, 6)) * 4;
            code = $urandom() | 32'h1;
            for (logic [31:0] a = b; a < e; a += 4) mem[a] = $urandom();
            do_reset();
            run_dump($sformatf("rand%0d", r), b, e, code, (r == 0) ? 0 : 1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tohost_signature_dumper.md
# tohost_signature_dumper

Target-side end of the `tohost` test-exit protocol. A memory-mapped device that sits on the core's data bus next to main memory. It latches core writes to the `tohost` word; on the first nonzero write it halts the core and reads the signature region out of memory one word at a time. Each word is streamed out over a valid/ready port, so FPGA and emulation runs can export a signature without a simulator peeking into memory.

## Interface

Parameters:
- `TOHOST_ADDR`, default `32'h0000_1000`: byte address of the `tohost` word; word-aligned.
- `ADDR_W`, default 32: bus and memory address width.

Ports:
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-high.
- `bus_addr`  in  `ADDR_W`  core data-bus byte address.
- `bus_we`  in  1  core write strobe; a full 32-bit word write.
- `bus_wdata`  in  32  core write data.
- `bus_rdata`  out  32  `tohost` register value, combinational; meaningful only when `bus_addr == TOHOST_ADDR`, else 0.
- `begin_sig`  in  `ADDR_W`  signature start byte address; word-aligned; stable while not IDLE.
- `end_sig`  in  `ADDR_W`  signature end byte address, exclusive; word-aligned; `end_sig >= begin_sig`.
- `mem_rd_en`  out  1  memory read request.
- `mem_rd_addr`  out  `ADDR_W`  memory read byte address.
- `mem_rd_data`  in  32  read data, valid exactly one cycle after `mem_rd_en`.
- `sig_valid`  out  1  signature word available.
- `sig_ready`  in  1  consumer accepts the word.
- `sig_data`  out  32  signature word.
- `sig_last`  out  1  marks the final word; qualified by `sig_valid`.
- `halt`  out  1  stall request to the core.
- `done`  out  1  dump complete, sticky until reset.
- `exit_code`  out  32  the latched `tohost` value.

## Operation

- `tohost` register: a 32-bit register that captures `bus_wdata` when `bus_we && bus_addr == TOHOST_ADDR` and the state is IDLE. Writes in any other state are ignored.
- States: IDLE, READ, WAIT, SEND, DONE.
- IDLE:
  - Zero write: register updates, state holds.
  - Nonzero write: register updates, `exit_code` latches, `halt` goes to 1, and the pointer `ptr` is loaded with `begin_sig`.
  - Next state is READ if `begin_sig != end_sig`, else DONE. An empty region emits no words.
- READ: assert `mem_rd_en` with `mem_rd_addr = ptr` for one cycle, then go to WAIT.
- WAIT: register `mem_rd_data` into `sig_data`, then go to SEND.
- SEND:
  - `sig_valid = 1`; `sig_last = (ptr + 4 == end_sig)`.
  - On `sig_ready`: `ptr += 4`. If the word was last, go to DONE, else go to READ.
  - `sig_data` and `sig_last` stay stable while `sig_valid && !sig_ready`.
- DONE: `done = 1`, `halt = 1`, no further memory reads. Left only by reset.
- Pointer arithmetic: `ADDR_W` bits, unsigned, step 4. Each word is emitted exactly once; there is no per-byte duplication. Pointer wrap past `2^ADDR_W` is unsupported because `end_sig` bounds it.
- `halt` is 1 in every state except IDLE.

## Timing

- Reset values: `tohost` = 0, `exit_code` = 0, `halt` = 0, `done` = 0, `sig_valid` = 0, `sig_last` = 0, `sig_data` = 0, `mem_rd_en` = 0, `mem_rd_addr` = 0, state = IDLE.
- The trigger write in cycle T gives `halt` = 1 in T+1.
- First word:
  - `mem_rd_en` in T+1.
  - `sig_valid` in T+3.
- Per-word throughput is 3 cycles with `sig_ready` tied high: READ, WAIT, SEND.
- `sig_ready` may be high before `sig_valid`. Transfer occurs only on a cycle where both are high.
- Empty region: `done` = 1 in T+2 (IDLE→DONE at T+1, registered output).
- `done` rises in the cycle after the `sig_last` handshake.
- Reset asserted in any state: all outputs return to reset values on the next edge. Any in-flight read data is discarded.
- A trigger write and reset in the same cycle: reset wins.

## Test plan

- Zero write to `TOHOST_ADDR` in IDLE → `bus_rdata` = 0, `halt` stays 0, no `mem_rd_en`.
- `begin_sig` = 0x2000, `end_sig` = 0x2010, memory words 0x11, 0x22, 0x33, 0x44; write 0x1 to `tohost` → exactly 4 beats 0x11, 0x22, 0x33, 0x44, `sig_last` on the fourth beat only, `exit_code` = 1, `done` one cycle later.
- Same setup with `sig_ready` low for 5 cycles on beat 2 → `sig_data` holds 0x22, no extra `mem_rd_en`, beat order intact.
- `begin_sig == end_sig` = 0x3000, write 0x5 → zero beats, `done` = 1 two cycles after the write, `exit_code` = 5.
- Write 0xDEAD to `tohost` during SEND → `exit_code` and `bus_rdata` unchanged.
- Reset pulsed during WAIT of word 2 → all outputs return to reset values. A subsequent trigger restarts the dump from `begin_sig`.
